// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared fetch-state enum, widths, program bases, branch LUT table and opcodes.
package cpu_defs;
  localparam int PC_W = 11;
  localparam int LUT_IDX_W = 5;
  localparam int REL_W = 6;
  localparam int CNT_W = 16;
  localparam int LUT_N = 8;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_e;
  localparam logic [LUT_N-1:0][PC_W-1:0] BRANCH_LUT = {
    11'h055, 11'h300, 11'h7FD, 11'h123, 11'h001, 11'h7FF, 11'h0A0, 11'h010
  };
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_HALT = 4'h1;
  localparam logic [3:0] OP_BRA = 4'h2;
  localparam logic [3:0] OP_BRR = 4'h3;
  function automatic logic [PC_W-1:0] prog_base(input logic [1:0] sel);
    return sel == 2'd1 ? 11'h200 : sel == 2'd2 ? 11'h400 : 11'h000;
  endfunction
endpackage

// File: rtl/branch_lut.sv
// branch_lut: combinational absolute branch target table; indices beyond the table give 0.
module branch_lut
  import cpu_defs::*;
(
  input  logic [LUT_IDX_W-1:0] idx_i,
  output logic [PC_W-1:0]      target_o
);
  assign target_o = (idx_i < LUT_IDX_W'(LUT_N)) ? BRANCH_LUT[idx_i[2:0]] : '0;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC/fetch sequencer for the instruction ROM; INST_FETCH_CNT_EN adds RetiredCnt.
module inst_fetch
  import cpu_defs::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [1:0]           ProgSel,
  input  logic                 Stall,
  input  logic                 Halt,
  input  logic                 BranchAbs,
  input  logic [LUT_IDX_W-1:0] BranchIdx,
  input  logic                 BranchRel,
  input  logic [REL_W-1:0]     RelOff,
  output logic [PC_W-1:0]      InstAddress,
  output logic                 Running,
  output logic                 Done,
  output logic                 Fault
`ifdef INST_FETCH_CNT_EN
  ,output logic [CNT_W-1:0]    RetiredCnt
`endif
);
  fetch_state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, lut_target;
  logic fault_q, fault_d;
  logic launch, advance;
  branch_lut u_lut (.idx_i(BranchIdx), .target_o(lut_target));
  assign launch = Start && state_q != RUN;
  assign advance = state_q == RUN && !Stall;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    fault_d = fault_q;
    if (launch) begin
      state_d = RUN;
      pc_d = prog_base(ProgSel);
      fault_d = 1'b0;
    end else if (advance) begin
      if (Halt) state_d = HALTED;
      else if (BranchAbs) pc_d = lut_target;
      else if (BranchRel) pc_d = pc_q + {{(PC_W-REL_W){RelOff[REL_W-1]}}, RelOff};
      else if (&pc_q) begin
        state_d = HALTED;
        fault_d = 1'b1;
      end else pc_d = pc_q + 1'b1;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      fault_q <= fault_d;
    end
  end
  assign InstAddress = pc_q;
  assign Running = state_q == RUN;
  assign Done = state_q == HALTED;
  assign Fault = fault_q;
`ifdef INST_FETCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = launch ? '0 : (advance && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge Clk) cnt_q <= Reset ? '0 : cnt_d;
  assign RetiredCnt = cnt_q;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed plus randomized checks of inst_fetch against a behavioural model.
module tb_inst_fetch;
  logic Clk = 1'b0;
  logic Reset = 1'b0, Start = 1'b0, Stall = 1'b0, Halt = 1'b0, BranchAbs = 1'b0, BranchRel = 1'b0;
  logic [1:0] ProgSel = '0;
  logic [4:0] BranchIdx = '0;
  logic [5:0] RelOff = '0;
  logic [10:0] InstAddress;
  logic Running, Done, Fault;
`ifdef INST_FETCH_CNT_EN
  logic [15:0] RetiredCnt;
`endif
  int checks = 0, failures = 0;
  int m_pc, m_st, m_fault, m_cnt;
  int lut [32];

  inst_fetch dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
    .Halt(Halt), .BranchAbs(BranchAbs), .BranchIdx(BranchIdx), .BranchRel(BranchRel),
    .RelOff(RelOff), .InstAddress(InstAddress), .Running(Running), .Done(Done),
    .Fault(Fault)
`ifdef INST_FETCH_CNT_EN
    , .RetiredCnt(RetiredCnt)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic int base_of(input int s);
    return s == 1 ? 'h200 : s == 2 ? 'h400 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model states: 0 idle, 1 running, 2 halted.
  task automatic model_edge();
    int off;
    off = int'($signed(RelOff));
    if (Reset) begin
      m_pc = 0; m_st = 0; m_fault = 0; m_cnt = 0;
    end else if (m_st != 1) begin
      if (Start) begin
        m_pc = base_of(int'(ProgSel)); m_fault = 0; m_cnt = 0; m_st = 1;
      end
    end else if (!Stall) begin
      if (m_cnt < 65535) m_cnt++;
      if (Halt) m_st = 2;
      else if (BranchAbs) m_pc = lut[BranchIdx];
      else if (BranchRel) m_pc = ((m_pc + off) % 2048 + 2048) % 2048;
      else if (m_pc == 2047) begin m_fault = 1; m_st = 2; end
      else m_pc = m_pc + 1;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    chk("pc", 32'(InstAddress), 32'(m_pc));
    chk("running", 32'(Running), 32'(m_st == 1));
    chk("done", 32'(Done), 32'(m_st == 2));
    chk("fault", 32'(Fault), 32'(m_fault));
`ifdef INST_FETCH_CNT_EN
    chk("retired", 32'(RetiredCnt), 32'(m_cnt));
`endif
    Reset = 0; Start = 0; Stall = 0; Halt = 0; BranchAbs = 0; BranchRel = 0;
  endtask

  task automatic go_abs(input int idx);
    BranchAbs = 1; BranchIdx = 5'(idx); tick();
  endtask

  initial begin
    foreach (lut[i]) lut[i] = 0;
    lut[0] = 'h010; lut[1] = 'h0A0; lut[2] = 'h7FF; lut[3] = 'h001;
    lut[4] = 'h123; lut[5] = 'h7FD; lut[6] = 'h300; lut[7] = 'h055;
    m_pc = 0; m_st = 0; m_fault = 0; m_cnt = 0;
    Reset = 1; tick();
    chk("reset_pc", 32'(InstAddress), 0);
    Start = 1; ProgSel = 1; tick();
    chk("start_base", 32'(InstAddress), 'h200);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("seq_pc", 32'(InstAddress), 32'('h200 + i));
      chk("seq_running", 32'(Running), 1);
    end
    Start = 1; ProgSel = 2; tick();
    chk("start_in_run_ignored", 32'(InstAddress), 'h206);
    go_abs(0);
    chk("abs_lut0", 32'(InstAddress), 'h010);
    BranchRel = 1; RelOff = 6'h3D; tick();
    chk("rel_minus3", 32'(InstAddress), 'h00D);
    go_abs(3);
    BranchRel = 1; RelOff = 6'h3C; tick();
    chk("rel_wrap_down", 32'(InstAddress), 'h7FD);
    BranchRel = 1; RelOff = 6'h05; tick();
    chk("rel_wrap_up", 32'(InstAddress), 'h002);
    BranchAbs = 1; BranchIdx = 4; BranchRel = 1; RelOff = 6'h01; tick();
    chk("abs_beats_rel", 32'(InstAddress), 'h123);
    Stall = 1; BranchAbs = 1; BranchIdx = 0; Halt = 1; tick();
    chk("stall_holds", 32'(InstAddress), 'h123);
    go_abs(20);
    chk("unmapped_lut", 32'(InstAddress), 0);
    go_abs(1);
    Halt = 1; BranchAbs = 1; BranchIdx = 0; tick();
    chk("halt_done", 32'(Done), 1);
    chk("halt_pc", 32'(InstAddress), 'h0A0);
    BranchAbs = 1; BranchIdx = 4; tick();
    chk("halted_ignores_branch", 32'(InstAddress), 'h0A0);
    Start = 1; ProgSel = 2; tick();
    chk("restart_base2", 32'(InstAddress), 'h400);
    chk("restart_done_clr", 32'(Done), 0);
    go_abs(2);
    tick();
    chk("eor_pc", 32'(InstAddress), 'h7FF);
    chk("eor_fault", 32'(Fault), 1);
    chk("eor_done", 32'(Done), 1);
    Start = 1; ProgSel = 3; tick();
    chk("sel3_base0", 32'(InstAddress), 0);
    chk("start_clears_fault", 32'(Fault), 0);
    go_abs(2);
    BranchRel = 1; RelOff = 6'h02; tick();
    chk("branch_from_last", 32'(InstAddress), 'h001);
    Reset = 1; tick();
    chk("midrun_reset_pc", 32'(InstAddress), 0);
    chk("midrun_reset_run", 32'(Running), 0);
`ifdef INST_FETCH_CNT_EN
    Start = 1; ProgSel = 0; tick();
    for (int i = 0; i < 10; i++) begin
      Stall = (i == 2 || i == 5 || i == 7);
      Halt = (i == 9);
      tick();
    end
    chk("retired_7", 32'(RetiredCnt), 7);
`endif
    for (int i = 0; i < 600; i++) begin
      Reset = ($urandom % 60) == 0;
      Start = ($urandom % 8) == 0;
      ProgSel = 2'($urandom);
      Stall = ($urandom % 4) == 0;
      Halt = ($urandom % 25) == 0;
      BranchAbs = ($urandom % 6) == 0;
      BranchIdx = 5'($urandom % 10);
      BranchRel = ($urandom % 5) == 0;
      RelOff = 6'($urandom);
      tick();
    end
`ifdef INST_FETCH_CNT_EN
    Reset = 1; tick();
    Start = 1; ProgSel = 0; tick();
    for (int i = 0; i < 65540; i++) go_abs(20);
    chk("retired_sat", 32'(RetiredCnt), 'hFFFF);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
